// File: rtl/decim_filt_pkg.sv
// Shared sizing helpers for the decimating FIR: accumulator width,
// saturation bounds and the clip-counter width.
package decim_filt_pkg;

  localparam int SAT_CNT_W = 16;

  function automatic int acc_width(input int dw, input int cw, input int nt);
    return dw + cw + $clog2(nt);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/decim_phase_cnt.sv
// Decimation phase counter: advances on every accepted input and flags the
// phase whose accept produces an output.
module decim_phase_cnt #(
  parameter int DECIM_FACTOR = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  output logic o_last
);

  localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;

  logic [PW-1:0] r_phase;

  assign o_last = (r_phase == PW'(DECIM_FACTOR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (i_accept) begin
      r_phase <= o_last ? '0 : r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/decim_filt.sv
// Decimating FIR with runtime-loadable coefficients and saturating output.
// Optional clipped-output counter enabled by DECIM_FILT_SAT_CNT_EN.
module decim_filt
  import decim_filt_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int TAP_COEFF_WIDTH = 8,
  parameter int NUM_TAPS        = 4,
  parameter int DECIM_FACTOR    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               in,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [DATA_WIDTH-1:0]               out,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic [NUM_TAPS*TAP_COEFF_WIDTH-1:0] tap_coeffs,
  input  logic                                coeff_load
`ifdef DECIM_FILT_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0]                sat_cnt
`endif
);

  localparam int DW    = DATA_WIDTH;
  localparam int CW    = TAP_COEFF_WIDTH;
  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_width(DW, CW, NUM_TAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DW));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DW));

  logic signed [DW-1:0]    r_d     [0:NUM_TAPS-2];
  logic signed [CW-1:0]    r_coeff [0:NUM_TAPS-1];
  logic signed [DW-1:0]    w_x     [0:NUM_TAPS-1];
  logic signed [PW-1:0]    w_prod  [0:NUM_TAPS-1];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_res;
  logic                    w_hi;
  logic                    w_lo;
  logic [DW-1:0]           w_sat;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_event;
  logic [DW-1:0]           r_out;
  logic                    r_out_valid;

  // Only the final phase can overwrite a held result, so only it stalls.
  assign in_ready  = !(r_out_valid && !out_ready && w_last);
  assign w_accept  = in_valid && in_ready;
  assign w_event   = w_accept && w_last;
  assign out       = r_out;
  assign out_valid = r_out_valid;

  decim_phase_cnt #(
    .DECIM_FACTOR(DECIM_FACTOR)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .i_accept(w_accept),
    .o_last  (w_last)
  );

  // Post-shift window: the incoming sample is tap 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign w_x[gi] = in;
      end else begin : g_tail
        assign w_x[gi] = r_d[gi-1];
      end
      assign w_prod[gi] = PW'(w_x[gi]) * PW'(r_coeff[gi]);
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_acc = w_acc + ACC_W'(w_prod[k]);
    end
  end

  assign w_res = w_acc >>> (CW - 1);
  assign w_hi  = (w_res > SAT_MAX);
  assign w_lo  = (w_res < SAT_MIN);
  assign w_sat = w_hi ? SAT_MAX[DW-1:0] : (w_lo ? SAT_MIN[DW-1:0] : w_res[DW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) r_d[k] <= '0;
      for (int k = 0; k < NUM_TAPS; k++) r_coeff[k] <= '0;
    end else begin
      if (w_accept) begin
        for (int k = 0; k < NUM_TAPS - 1; k++) r_d[k] <= w_x[k];
      end
      if (coeff_load) begin
        for (int k = 0; k < NUM_TAPS; k++) r_coeff[k] <= tap_coeffs[k*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_event) begin
      r_out       <= w_sat;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DECIM_FILT_SAT_CNT_EN
  logic                 w_clip;
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  assign w_clip  = w_hi || w_lo;
  assign sat_cnt = r_sat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_cnt <= '0;
    end else if (w_event && w_clip && (r_sat_cnt != {SAT_CNT_W{1'b1}})) begin
      r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decim_filt.sv
// Scoreboard bench for decim_filt: directed vectors push expected results,
// a negedge monitor pops and compares each consumed output.
module tb_decim_filt;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] tap_coeffs;
  logic        coeff_load;
`ifdef DECIM_FILT_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  decim_filt dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tap_coeffs(tap_coeffs),
    .coeff_load(coeff_load)
`ifdef DECIM_FILT_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  // Monitor: one consume per negedge where valid && ready.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      int e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %0d, expected no output", $signed(out));
      end else begin
        e = exp_q.pop_front();
        if (int'($signed(out)) !== e) begin
          n_bad++;
          $display("FAIL out_sample: got %0d, expected %0d", $signed(out), e);
        end else begin
          $display("out sample %0d (expected %0d)", $signed(out), e);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic int model(input int x0, input int x1, input int x2, input int x3);
    int acc;
    acc = 64 * x0 + 32 * x1 + 16 * x2 + 8 * x3;
    acc = acc >>> 7;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic send(input int s);
    logic acc;
    int   n;
    in       = 8'(s);
    in_valid = 1'b1;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: sample %0d not accepted within %0d cycles", s, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] c);
    tap_coeffs = c;
    coeff_load = 1'b1;
    @(posedge clk);
    #1;
    coeff_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, h2;
    rst        = 1'b0;
    in         = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    tap_coeffs = '0;
    coeff_load = 1'b0;

    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out", int'(out), 0);
    check("reset_in_ready", int'(in_ready), 1);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Impulse response
    load(pack(64, 32, 16, 8));
    send(100);
    check("impulse_no_early_valid", int'(out_valid), 0);
    exp_q.push_back(25);
    send(0);
    check("impulse_latency_valid", int'(out_valid), 1);
    check("impulse_latency_out", int'($signed(out)), 25);
    send(0);
    exp_q.push_back(6);
    send(0);
    send(0);
    exp_q.push_back(0);
    send(0);
    drain();

    // Saturation and floor rounding
    load(pack(127, 127, 127, 127));
    send(127);
    exp_q.push_back(127);
    send(127);
    send(127);
    exp_q.push_back(127);
    send(127);
    send(-128);
    exp_q.push_back(-2);
    send(-128);
    send(-128);
    exp_q.push_back(-128);
    send(-128);
    drain();
`ifdef DECIM_FILT_SAT_CNT_EN
    check("sat_cnt", int'(sat_cnt), 3);
`endif

    // Backpressure
    load(pack(64, 0, 0, 0));
    send(10);
    exp_q.push_back(10);
    send(20);
    out_ready = 1'b0;
    check("bp_valid_held", int'(out_valid), 1);
    send(30);
    exp_q.push_back(-21);
    in       = 8'(-41);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_held", int'($signed(out)), 10);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_consume_produce_valid", int'(out_valid), 1);
    check("bp_consume_produce_out", int'($signed(out)), -21);
    drain();

    // Coefficient load coinciding with an output event
    send(50);
    exp_q.push_back(30);
    tap_coeffs = pack(0, 64, 0, 0);
    coeff_load = 1'b1;
    send(60);
    coeff_load = 1'b0;
    send(70);
    exp_q.push_back(35);
    send(80);
    drain();

    // Asynchronous reset with a pending output and a partial frame
    out_ready = 1'b0;
    send(90);
    send(100);
    send(10);
    check("pending_before_rst", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out", int'(out), 0);
    check("async_rst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(pack(64, 32, 16, 8));
    send(40);
    check("post_rst_phase", int'(out_valid), 0);
    exp_q.push_back(50);
    send(80);
    drain();

    // Ramp with random input bubbles against the golden model
    h0 = 80;
    h1 = 40;
    h2 = 0;
    for (int i = 1; i <= 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if (i % 2 == 0) exp_q.push_back(model(i, h0, h1, h2));
      send(i);
      h2 = h1;
      h1 = h0;
      h0 = i;
    end
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decim_filt.md
Name: decim_filt

Overview:
Decimating FIR filter: the receive-side counterpart of the interpolation filter in the same sample-rate-conversion datapath. Accepts one input sample per valid/ready handshake and runs a NUM_TAPS FIR over the most recent samples. Emits one filtered sample per DECIM_FACTOR accepted inputs on a valid/ready output port. Coefficients are runtime-loadable; arithmetic is signed fixed-point with saturation.

Parameters:
DATA_WIDTH, 8, signed sample width (input and output)
TAP_COEFF_WIDTH, 8, signed coefficient width, Q1.(TAP_COEFF_WIDTH-1) format
NUM_TAPS, 4, FIR length, >=2
DECIM_FACTOR, 2, inputs consumed per output, >=2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in  input  DATA_WIDTH  signed input sample
in_valid  input  1  in holds a sample
in_ready  output  1  block accepts in this cycle
out  output  DATA_WIDTH  signed filtered sample, held while out_valid
out_valid  output  1  out holds an unconsumed result
out_ready  input  1  downstream accepts out
tap_coeffs  input  TAP_COEFF_WIDTH x NUM_TAPS  signed coefficients, index k multiplies x[n-k]
coeff_load  input  1  capture tap_coeffs into internal coefficient registers this cycle

Behaviour:
- Reset (rst=0, async): delay line = 0, coefficient regs = 0, phase = 0, out = 0, out_valid = 0. in_ready depends only on state, so it is 1 during reset. Reset mid-frame discards the partial phase and any pending output.
- Accept: an input sample is accepted on an edge where in_valid && in_ready. On accept, the delay line shifts: d[0] <= in, d[k] <= d[k-1].
- Phase counter: 0..DECIM_FACTOR-1, increments on each accept and wraps to 0 after DECIM_FACTOR-1.
- Output production: an accept when phase == DECIM_FACTOR-1 is an output event.
  - The result is computed combinationally from {in, d[0..NUM_TAPS-2]}, i.e. the post-shift window.
  - It is registered into out, with out_valid <= 1, on the same edge.
  - Latency: out_valid is high the cycle after the last-phase accept.
  - The first output follows the DECIM_FACTOR-th accepted input after reset.
- Arithmetic:
  - acc = sum over k of c[k]*x[n-k], full precision, width DATA_WIDTH+TAP_COEFF_WIDTH+clog2(NUM_TAPS).
  - res = acc >>> (TAP_COEFF_WIDTH-1), arithmetic shift, floor.
  - Saturate res to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output handshake: out_valid clears on an edge with out_ready && !(new output event). Simultaneous consume and produce loads the new result with out_valid staying 1.
- Backpressure: in_ready = !(out_valid && !out_ready && phase == DECIM_FACTOR-1). Non-final phases are always accepted, since they never overwrite out. Results are never dropped.
- Coefficients: coeff_load=1 captures tap_coeffs on that edge. An output event on the same edge uses the old coefficients. Coefficients persist until the next load or reset.
- in_valid=0: no state change except output consumption.

Optional Feature:
Macro DECIM_FILT_SAT_CNT_EN.
- Defined: adds output port sat_cnt [15:0]. It counts output events whose result was clipped, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package decim_filt_pkg holds:
  - accumulator width function (DATA_WIDTH+TAP_COEFF_WIDTH+clog2(NUM_TAPS))
  - saturation min/max constant functions
  - the sat_cnt width constant (16)
- One sub-module: decim_phase_cnt. It holds the phase counter plus the last-phase flag, and takes accept as input. The MAC/saturate logic stays inline.

Test Plan:
(All with defaults, DATA_WIDTH=8, TAP_COEFF_WIDTH=8, NUM_TAPS=4, DECIM_FACTOR=2, out_ready=1.)
- Impulse: load coeffs {64,32,16,8}, feed 100,0,0,0,0,0 -> outputs 25, 6, 0. out_valid pulses one cycle after inputs 2, 4, 6.
- Saturation: coeffs all 127, constant input 127 -> out=127; constant input -128 -> out=-128. With DECIM_FILT_SAT_CNT_EN, sat_cnt increments once per output.
- Backpressure: out_ready=0 after first output, in_valid held 1 -> next input accepted (phase 0), the following one stalls (in_ready=0). out holds its value. Raising out_ready gives a same-edge consume+produce with out_valid staying 1.
- Coefficient update: coeff_load on the same edge as an output event -> that output uses old coeffs; the next output uses the new ones.
- Async reset mid-frame: assert rst=0 after one accepted input with a pending output -> out_valid=0 and out=0 immediately, without a clock edge. After release, the first output requires 2 fresh inputs and reflects zeroed history.
- Bubbles: random in_valid gaps with a ramp 1..20 -> output sequence matches a software golden model, with no lost or duplicated samples.
